// File: rtl/access_enable_burst_reader_pkg.sv
// Shared types and sizing for the access-enable burst reader.
// FSM state encoding and output buffer depth live here so the top and buffer agree.
package access_enable_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      READING  = 2'd1,
      DRAINING = 2'd2
   } state_t;

   localparam int BUFFER_DEPTH = 2;
   localparam int COUNT_WIDTH  = $clog2(BUFFER_DEPTH + 1);

endpackage

// File: rtl/access_enable_burst_reader_buffer.sv
// Two-entry in-order skid buffer between the FIFO read port and the output stream.
// The head register is always the oldest entry so it can drive output_data directly.
module access_enable_burst_reader_buffer
   import access_enable_burst_reader_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [WIDTH-1:0]       head_data
);

   logic [WIDTH-1:0]       head_q;
   logic [WIDTH-1:0]       tail_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   pop_ok;
   logic                   push_ok;

   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && ((count_q != COUNT_WIDTH'(BUFFER_DEPTH)) || pop_ok);

   // Entries shift toward the head on pop; a push lands in the first free slot.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_q == '0) head_q <= push_data;
               else               tail_q <= push_data;
               count_q <= count_q + COUNT_WIDTH'(1);
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - COUNT_WIDTH'(1);
            end
            2'b11: begin
               if (count_q == COUNT_WIDTH'(1)) begin
                  head_q <= push_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign count     = count_q;
   assign head_data = head_q;

endmodule

// File: rtl/access_enable_burst_reader.sv
// Drains a commanded number of FIFO entries onto a valid/ready stream.
// Optional abort support is enabled with `define ACCESS_ENABLE_BURST_READER_ABORT_EN.
module access_enable_burst_reader
   import access_enable_burst_reader_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int LENGTH_WIDTH = 8
)
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [LENGTH_WIDTH-1:0] start_length,
   output logic                    busy,
   output logic                    done,
   output logic                    fifo_read_enable,
   input  logic [WIDTH-1:0]        fifo_read_data,
   input  logic                    fifo_read_empty,
   output logic                    output_valid,
   output logic [WIDTH-1:0]        output_data,
   input  logic                    output_ready
`ifdef ACCESS_ENABLE_BURST_READER_ABORT_EN
   ,
   input  logic                    abort,
   output logic                    aborted
`endif
);

   state_t                  state;
   state_t                  next_state;
   logic [LENGTH_WIDTH-1:0] remaining;
   logic [COUNT_WIDTH-1:0]  count;
   logic                    buffer_pop;
   logic                    start_accept;
   logic                    drain_empty;
   logic                    abort_hit;

`ifdef ACCESS_ENABLE_BURST_READER_ABORT_EN
   assign abort_hit = abort && (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // A start arriving while done is still high is held off one cycle.
   assign start_accept = (state == IDLE) && start && !done;
   assign buffer_pop   = output_valid && output_ready;
   assign drain_empty  = (count == '0) || ((count == COUNT_WIDTH'(1)) && buffer_pop);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (abort_hit) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:     if (start_accept && (start_length != '0)) next_state = READING;
            READING:  if (fifo_read_enable && (remaining == LENGTH_WIDTH'(1))) next_state = DRAINING;
            DRAINING: if (drain_empty) next_state = IDLE;
            default:  next_state = IDLE;
         endcase
      end
   end

   // The read strobe never looks at output_ready; buffer occupancy provides the backpressure.
   always_comb begin
      busy             = (state != IDLE);
      output_valid     = (count != '0);
      fifo_read_enable = (state == READING) && !reset && !abort_hit && !fifo_read_empty &&
                         (remaining != '0) && (count != COUNT_WIDTH'(BUFFER_DEPTH));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         remaining <= '0;
         done      <= 1'b0;
      end else begin
         if (abort_hit)             remaining <= '0;
         else if (start_accept)     remaining <= start_length;
         else if (fifo_read_enable) remaining <= remaining - LENGTH_WIDTH'(1);
         done <= abort_hit || (start_accept && (start_length == '0)) ||
                 ((state == DRAINING) && drain_empty);
      end
   end

`ifdef ACCESS_ENABLE_BURST_READER_ABORT_EN
   always_ff @(posedge clock) begin
      if (reset) aborted <= 1'b0;
      else       aborted <= abort_hit;
   end
`endif

   access_enable_burst_reader_buffer #(
      .WIDTH (WIDTH)
   ) u_buffer (
      .clock     (clock),
      .reset     (reset),
      .flush     (abort_hit),
      .push      (fifo_read_enable),
      .push_data (fifo_read_data),
      .pop       (buffer_pop),
      .count     (count),
      .head_data (output_data)
   );

endmodule
